// File: rtl/imem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// imem_arbiter_pkg
// Shared types and defaults for the instruction-memory arbiter slice.
//   arbState_e : arbiter phase (BOOT while the loader fills memory, RUN after)
//   owner_e    : who owns the read response returning next cycle
//   DEFAULT_STARVE_LIMIT : default denial count before the loader is forced in
// ----------------------------------------------------------------------------
package imem_arbiter_pkg;

   localparam int unsigned DEFAULT_STARVE_LIMIT = 4;

   typedef enum logic [0:0] {
      BOOT = 1'b0,
      RUN  = 1'b1
   } arbState_e;

   typedef enum logic [1:0] {
      NONE   = 2'd0,
      FETCH  = 2'd1,
      LOADER = 2'd2
   } owner_e;

endpackage

// File: rtl/imem_arbiter_starve_counter.sv
// ----------------------------------------------------------------------------
// starve_counter
// Counts consecutive cycles a loader request has been denied, saturating at
// LIMIT.
//   clk, reset : clock and synchronous active-high reset
//   inc_i      : request pending and denied this cycle
//   clr_i      : request granted or withdrawn this cycle (wins over inc_i)
//   sat_o      : count has reached LIMIT
// ----------------------------------------------------------------------------
module starve_counter #(
   parameter int unsigned LIMIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic inc_i,
   input  logic clr_i,
   output logic sat_o
);

   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   // Clear has priority; otherwise count up until the limit and hold there.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = 4'd0;
      end else if (inc_i && (cnt_q != 4'(LIMIT))) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign sat_o = (cnt_q == 4'(LIMIT));

endmodule

// File: rtl/imem_arbiter.sv
// ----------------------------------------------------------------------------
// imem_arbiter
// Two-port arbiter in front of a single-port instruction memory. During BOOT
// only the loader may access memory; after boot_done the fetch unit has
// priority, with a starvation counter forcing a loader grant periodically.
// Reads return one cycle after the grant, steered by a registered owner tag.
//   clk, reset               : clock, synchronous active-high reset
//   f_req/f_addr             : fetch read request and byte address
//   f_gnt/f_rvalid/f_rdata   : fetch grant, read valid, read data
//   l_req/l_we/l_addr/l_wdata: loader request, write enable, address, data
//   l_gnt/l_rvalid/l_rdata   : loader grant, read valid, read data
//   l_err                    : pulse after an out-of-range loader grant
//   boot_done                : ends the boot phase
//   fetch_stall              : fetch requested but not granted
//   mem_*                    : external single-port memory interface
// ----------------------------------------------------------------------------
module imem_arbiter
   import imem_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
   parameter int unsigned AW           = 9
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          f_req,
   input  logic [31:0]   f_addr,
   output logic          f_gnt,
   output logic          f_rvalid,
   output logic [31:0]   f_rdata,
   input  logic          l_req,
   input  logic          l_we,
   input  logic [31:0]   l_addr,
   input  logic [31:0]   l_wdata,
   output logic          l_gnt,
   output logic          l_rvalid,
   output logic [31:0]   l_rdata,
   output logic          l_err,
   input  logic          boot_done,
   output logic          fetch_stall,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata
);

   arbState_e state_q, state_d;
   owner_e    owner_q, owner_d;
   logic      err_q, err_d;
   logic      starveSat;
   logic      lInRange;
   logic      fAddrUnused;

   // Fetch addresses are word aligned by construction; only the word bits matter.
   assign fAddrUnused = ^{f_addr[31:AW+2], f_addr[1:0]};

   // Loader accesses beyond the memory or not word aligned are rejected.
   assign lInRange = (l_addr[31:AW+2] == '0) && (l_addr[1:0] == 2'b00);

   // Grant selection. Grants are blocked while reset is high so that nothing
   // reaches memory during the reset cycle even if the phase register has not
   // yet returned to BOOT.
   always_comb begin
      f_gnt = 1'b0;
      l_gnt = 1'b0;
      if (!reset) begin
         if (state_q == BOOT) begin
            l_gnt = l_req;
         end else if (starveSat) begin
            l_gnt = l_req;
         end else begin
            f_gnt = f_req;
            l_gnt = l_req & ~f_req;
         end
      end
   end

   // Phase, response owner and error pulse for the next cycle.
   always_comb begin
      state_d = state_q;
      if ((state_q == BOOT) && boot_done) begin
         state_d = RUN;
      end
      owner_d = NONE;
      if (f_gnt) begin
         owner_d = FETCH;
      end else if (l_gnt && !l_we && lInRange) begin
         owner_d = LOADER;
      end
      err_d = l_gnt & ~lInRange;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= BOOT;
         owner_q <= NONE;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         err_q   <= err_d;
      end
   end

   starve_counter #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk   (clk),
      .reset (reset),
      .inc_i (l_req & ~l_gnt),
      .clr_i (~l_req | l_gnt),
      .sat_o (starveSat)
   );

   assign fetch_stall = f_req & ~f_gnt;

   assign mem_en    = f_gnt | (l_gnt & lInRange);
   assign mem_we    = l_we & l_gnt & lInRange;
   assign mem_addr  = f_gnt ? f_addr[AW+1:2] : l_addr[AW+1:2];
   assign mem_wdata = l_wdata;

   // Responses are masked during reset so a read granted just before reset
   // never produces a valid.
   assign f_rvalid = (owner_q == FETCH) & ~reset;
   assign l_rvalid = (owner_q == LOADER) & ~reset;
   assign l_err    = err_q & ~reset;
   assign f_rdata  = f_rvalid ? mem_rdata : 32'd0;
   assign l_rdata  = l_rvalid ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_imem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_imem_arbiter
// Directed bench for imem_arbiter with a behavioural memory and a scoreboard
// of expected read responses.
// ----------------------------------------------------------------------------
module tb_imem_arbiter;

   logic        clk;
   logic        reset;
   logic        f_req;
   logic [31:0] f_addr;
   logic        f_gnt;
   logic        f_rvalid;
   logic [31:0] f_rdata;
   logic        l_req;
   logic        l_we;
   logic [31:0] l_addr;
   logic [31:0] l_wdata;
   logic        l_gnt;
   logic        l_rvalid;
   logic [31:0] l_rdata;
   logic        l_err;
   logic        boot_done;
   logic        fetch_stall;
   logic        mem_en;
   logic        mem_we;
   logic [8:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   typedef struct packed {
      int          due;
      logic [2:0]  resp;
      logic [31:0] fdata;
      logic [31:0] ldata;
   } resp_t;

   localparam logic [2:0] R_FETCH  = 3'b100;
   localparam logic [2:0] R_LOADER = 3'b010;
   localparam logic [2:0] R_ERR    = 3'b001;

   resp_t       sb[$];
   int          cyc;
   int          nCompared;
   int          nMismatched;
   logic        monEn;
   logic        memInit;
   logic [31:0] mem [512];

   imem_arbiter #(
      .STARVE_LIMIT (4),
      .AW           (9)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .f_req       (f_req),
      .f_addr      (f_addr),
      .f_gnt       (f_gnt),
      .f_rvalid    (f_rvalid),
      .f_rdata     (f_rdata),
      .l_req       (l_req),
      .l_we        (l_we),
      .l_addr      (l_addr),
      .l_wdata     (l_wdata),
      .l_gnt       (l_gnt),
      .l_rvalid    (l_rvalid),
      .l_rdata     (l_rdata),
      .l_err       (l_err),
      .boot_done   (boot_done),
      .fetch_stall (fetch_stall),
      .mem_en      (mem_en),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle stamp used to schedule expected responses
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural single-port memory with one-cycle read latency
   always @(posedge clk) begin
      if (memInit) begin
         for (int i = 0; i < 512; i++) mem[i] <= {16'hC0DE, 16'(i)};
      end else if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata <= mem[mem_addr];
      end
   end

   // Word contents the bench expects once the boot writes have landed
   function automatic logic [31:0] expWord(input int i);
      case (i)
         0:       expWord = 32'h0000_0013;
         1:       expWord = 32'h0010_0093;
         default: expWord = {16'hC0DE, 16'(i)};
      endcase
   endfunction

   // Schedule a response for the cycle after the current one
   task automatic expectResp(input logic [2:0] r, input logic [31:0] d);
      resp_t e;
      e.due   = cyc + 1;
      e.resp  = r;
      e.fdata = r[2] ? d : 32'd0;
      e.ldata = r[1] ? d : 32'd0;
      sb.push_back(e);
   endtask

   // Response monitor: every cycle the response outputs must match either
   // the scheduled entry or silence.
   always @(negedge clk) begin
      if (monEn) begin
         resp_t e;
         e = '0;
         if (sb.size() > 0 && sb[0].due == cyc) e = sb.pop_front();
         nCompared++;
         assert ({f_rvalid, l_rvalid, l_err} === e.resp) else begin
            nMismatched++;
            $error("[TB] FAIL resp@%0d: observed %b expected %b", cyc, {f_rvalid, l_rvalid, l_err}, e.resp);
         end
         nCompared++;
         assert (f_rdata === e.fdata) else begin
            nMismatched++;
            $error("[TB] FAIL f_rdata@%0d: observed %h expected %h", cyc, f_rdata, e.fdata);
         end
         nCompared++;
         assert (l_rdata === e.ldata) else begin
            nMismatched++;
            $error("[TB] FAIL l_rdata@%0d: observed %h expected %h", cyc, l_rdata, e.ldata);
         end
      end
   end

   // Drive one cycle of inputs just after the rising edge
   task automatic applyStimulus(input logic fr, input logic [31:0] fa,
                                input logic lr, input logic lwe,
                                input logic [31:0] la, input logic [31:0] lwd,
                                input logic bd);
      @(posedge clk);
      #1;
      f_req     = fr;
      f_addr    = fa;
      l_req     = lr;
      l_we      = lwe;
      l_addr    = la;
      l_wdata   = lwd;
      boot_done = bd;
   endtask

   // Check the combinational grant/memory outputs mid-cycle
   task automatic checkOutput(input string tag, input logic eFg, input logic eLg,
                              input logic eStall, input logic eEn, input logic eWe,
                              input int eWord);
      @(negedge clk);
      nCompared++;
      assert ({f_gnt, l_gnt} === {eFg, eLg}) else begin
         nMismatched++;
         $error("[TB] FAIL %s gnt: observed %b expected %b", tag, {f_gnt, l_gnt}, {eFg, eLg});
      end
      nCompared++;
      assert (fetch_stall === eStall) else begin
         nMismatched++;
         $error("[TB] FAIL %s stall: observed %b expected %b", tag, fetch_stall, eStall);
      end
      nCompared++;
      assert ({mem_en, mem_we} === {eEn, eWe}) else begin
         nMismatched++;
         $error("[TB] FAIL %s mem_en/we: observed %b expected %b", tag, {mem_en, mem_we}, {eEn, eWe});
      end
      if (eEn) begin
         nCompared++;
         assert (mem_addr === 9'(eWord)) else begin
            nMismatched++;
            $error("[TB] FAIL %s mem_addr: observed %0d expected %0d", tag, mem_addr, eWord);
         end
      end
   endtask

   initial begin
      cyc         = 0;
      nCompared   = 0;
      nMismatched = 0;
      monEn       = 1'b0;
      memInit     = 1'b1;
      reset       = 1'b1;
      f_req       = 1'b0;
      f_addr      = 32'd0;
      l_req       = 1'b0;
      l_we        = 1'b0;
      l_addr      = 32'd0;
      l_wdata     = 32'd0;
      boot_done   = 1'b0;

      @(posedge clk);
      monEn = 1'b1;
      checkOutput("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      @(posedge clk);
      #1;
      reset   = 1'b0;
      memInit = 1'b0;
      checkOutput("boot_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

      // Boot writes with fetch pending: loader only
      applyStimulus(1'b1, 32'h0, 1'b1, 1'b1, 32'h0, 32'h0000_0013, 1'b0);
      checkOutput("boot_wr0", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0);
      applyStimulus(1'b1, 32'h0, 1'b1, 1'b1, 32'h4, 32'h0010_0093, 1'b0);
      checkOutput("boot_wr1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1);

      // End of boot: fetch still blocked during the pulse, granted after
      applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      checkOutput("boot_pulse", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      expectResp(R_FETCH, expWord(1));
      checkOutput("run_fetch", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1);

      // Starvation: four fetch grants, then the loader read is forced in
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b1, 32'h8, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
         expectResp(R_FETCH, expWord(2));
         checkOutput("starve_f", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2);
      end
      applyStimulus(1'b1, 32'h8, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      expectResp(R_LOADER, expWord(0));
      checkOutput("starve_l", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0);

      // Out-of-range loader accesses: granted, no memory access, error pulse
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h1000, 32'h0, 1'b0);
      expectResp(R_ERR, 32'd0);
      checkOutput("oor_high", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h2, 32'h0, 1'b0);
      expectResp(R_ERR, 32'd0);
      checkOutput("oor_misalign", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);

      // Back-to-back fetch burst over words 0..7
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 32'(4 * i), 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
         expectResp(R_FETCH, expWord(i));
         checkOutput("burst", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, i);
      end

      // Simultaneous rise: fetch wins, loader served once fetch drops
      applyStimulus(1'b1, 32'hC, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
      expectResp(R_FETCH, expWord(3));
      checkOutput("tie_fetch", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
      expectResp(R_LOADER, expWord(1));
      checkOutput("tie_loader", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

      // Reset with a fetch read in flight: response discarded, back to BOOT
      applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("pre_reset", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4);
      @(posedge clk);
      #1;
      reset = 1'b1;
      checkOutput("in_reset", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      checkOutput("boot_again", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("final_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

      @(posedge clk);
      nCompared++;
      assert (sb.size() == 0) else begin
         nMismatched++;
         $error("[TB] FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, meaning the number of consecutive cycles a loader request may be denied before it is forced a grant (range 1..15).
REQ-002 Parameter AW, default 9, meaning the instruction-memory word-address width; byte address bits [AW+1:2] select the word.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 f_req  input  1  fetch-side read request.
REQ-006 f_addr  input  32  fetch byte address (the pc).
REQ-007 f_gnt  output  1  fetch request accepted this cycle.
REQ-008 f_rvalid  output  1  fetch read data valid.
REQ-009 f_rdata  output  32  fetch read data (instruction).
REQ-010 l_req  input  1  loader/debug request.
REQ-011 l_we  input  1  loader write (1) or read (0).
REQ-012 l_addr  input  32  loader byte address.
REQ-013 l_wdata  input  32  loader write data.
REQ-014 l_gnt  output  1  loader request accepted this cycle.
REQ-015 l_rvalid  output  1  loader read data valid.
REQ-016 l_rdata  output  32  loader read data.
REQ-017 l_err  output  1  one-cycle pulse: granted loader access was out of range.
REQ-018 boot_done  input  1  single-cycle pulse ending the boot phase.
REQ-019 fetch_stall  output  1  high when f_req is asserted and f_gnt is low; drives the fetch unit's stall input.
REQ-020 mem_en, mem_we  output  1 each  memory enable / write enable.
REQ-021 mem_addr  output  AW  memory word address.
REQ-022 mem_wdata  output  32  memory write data.
REQ-023 mem_rdata  input  32  memory read data, valid one cycle after mem_en with mem_we=0.

Function
REQ-024 The FSM SHALL have states BOOT and RUN; reset enters BOOT.
REQ-025 In BOOT, only the loader is granted: l_gnt = l_req, f_gnt = 0.
REQ-026 BOOT -> RUN on the cycle after boot_done=1; boot_done in RUN is ignored.
REQ-027 In RUN, fetch has priority: f_gnt = f_req unless the starvation counter equals STARVE_LIMIT, in which case l_gnt = l_req and f_gnt = 0.
REQ-028 The starvation counter SHALL increment each cycle l_req=1 and l_gnt=0, clear on l_gnt or l_req=0, and saturate at STARVE_LIMIT.
REQ-029 At most one of f_gnt and l_gnt SHALL be high in any cycle; combinational from the current request inputs and the registered state.
REQ-030 On any grant, mem_en=1 and mem_addr = granted address [AW+1:2]; mem_we = l_we & l_gnt & in-range; mem_wdata = l_wdata.
REQ-031 A loader access is out of range when l_addr[31:AW+2] is not zero or l_addr[1:0] is not zero; it SHALL be granted, SHALL NOT assert mem_en, and SHALL pulse l_err one cycle after the grant, with l_rvalid = 0.
REQ-032 Read latency SHALL be exactly 1 cycle: a registered owner tag asserts f_rvalid or l_rvalid in the cycle after a read grant, and the corresponding rdata equals mem_rdata; writes produce no rvalid.
REQ-033 f_rdata and l_rdata SHALL be mem_rdata gated to zero when the corresponding rvalid is low.
REQ-034 Back-to-back grants every cycle SHALL be supported (full throughput, no bubbles).
REQ-035 If f_req and l_req rise in the same cycle in RUN with the counter below the limit, the fetch request SHALL win.

Reset
REQ-036 While reset=1: state=BOOT, counter=0, owner tag=none; on the following cycle f_rvalid, l_rvalid, l_err = 0.
REQ-037 A reset asserted while a read is in flight SHALL discard that response; no rvalid is issued.

Structure
REQ-038 A shared package SHALL hold the FSM state enum (BOOT, RUN), the owner-tag enum (NONE, FETCH, LOADER) and the default STARVE_LIMIT constant.
REQ-039 The starvation counter SHALL be a sub-module starve_counter (inc, clr, sat output); the memory itself is external.

Verification
REQ-040 Reset, then l_req=1 and l_we=1 to addresses 0x0 and 0x4 with data 0x00000013 and 0x00100093 while f_req=1 -> l_gnt=1 in both cycles, f_gnt=0, fetch_stall=1, two memory writes.
REQ-041 Pulse boot_done, then f_req=1 at addr 0x4 -> f_gnt=1 in the second cycle after the pulse, f_rvalid=1 with f_rdata=0x00100093 one cycle later.
REQ-042 In RUN, hold f_req=1 and l_req=1 (read 0x0) with STARVE_LIMIT=4 -> four fetch grants, then l_gnt=1 in cycle 5 with fetch_stall=1, l_rvalid=1 and l_rdata=0x00000013 in cycle 6.
REQ-043 Loader read at 0x1000 and at 0x2 -> l_gnt=1, mem_en=0, l_err pulse one cycle later each time, no l_rvalid.
REQ-044 Issue a fetch read grant, then assert reset in the next cycle -> f_rvalid stays 0, state returns to BOOT, and f_gnt=0 while l_req=0.
REQ-045 Continuous f_req with incrementing addresses 0x0..0x1C in RUN -> eight consecutive f_gnt and eight consecutive f_rvalid, each offset by exactly one cycle.
